// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable data width, parity and stop bits.
// A received frame is held on the outputs until the consumer acknowledges it.
module uart_rx_param #(
    parameter int BAUD_DIV   = 54,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RsRx,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
    localparam logic [15:0]   BAUD_M1 = 16'(BAUD_DIV - 1);
    localparam logic [3:0]    DATA_M1 = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_M1 = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [15:0]            baud_cnt_q, baud_cnt_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic                   perr_acc_q, perr_acc_d;
    logic                   armed_q, armed_d;
    logic [DATA_BITS-1:0]   data_out_q, data_out_d;
    logic                   data_ready_q, data_ready_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q, overrun_d;
    logic                   rx, tick, done;

    assign rx   = sync_q[1];
    assign tick = (baud_cnt_q == BAUD_M1);

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        sync_d     = {sync_q[0], RsRx};
        baud_cnt_d = tick ? 16'd0 : baud_cnt_q + 16'd1;
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ferr_acc_d = ferr_acc_q;
        perr_acc_d = perr_acc_q;
        armed_d    = armed_q;
        done       = 1'b0;

        case (state_q)
            IDLE: if (tick) begin
                // A start is only accepted after the line has been seen high,
                // so a held break yields a single frame.
                if (rx) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end
            START: if (tick) begin
                if (tick_cnt_q == HALF_M1) begin
                    tick_cnt_d = '0;
                    if (!rx) begin
                        state_d    = DATA;
                        bit_cnt_d  = '0;
                        ferr_acc_d = 1'b0;
                        perr_acc_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            DATA: if (tick) begin
                if (tick_cnt_q == FULL_M1) begin
                    tick_cnt_d = '0;
                    shift_d    = {rx, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == DATA_M1) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            PAR: if (tick) begin
                if (tick_cnt_q == FULL_M1) begin
                    tick_cnt_d = '0;
                    perr_acc_d = (PARITY == 1) ? ~(^shift_q ^ rx) : (^shift_q ^ rx);
                    state_d    = STOP;
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            STOP: if (tick) begin
                if (tick_cnt_q == FULL_M1) begin
                    tick_cnt_d = '0;
                    if (!rx) ferr_acc_d = 1'b1;
                    if (bit_cnt_q == STOP_M1) begin
                        done      = 1'b1;
                        bit_cnt_d = '0;
                        armed_d   = rx;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_out_d   = data_out_q;
        data_ready_d = data_ready_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
        if (done) begin
            // Completion beats a same-cycle acknowledge.
            data_out_d   = shift_q;
            frame_err_d  = ferr_acc_q | ~rx;
            parity_err_d = perr_acc_q;
            data_ready_d = 1'b1;
            overrun_d    = (rd_ack && data_ready_q) ? 1'b0 : (overrun_q | data_ready_q);
        end else if (rd_ack && data_ready_q) begin
            data_ready_d = 1'b0;
            overrun_d    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset covers every flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            baud_cnt_q   <= '0;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            ferr_acc_q   <= 1'b0;
            perr_acc_q   <= 1'b0;
            armed_q      <= 1'b0;
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            baud_cnt_q   <= baud_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ferr_acc_q   <= ferr_acc_d;
            perr_acc_q   <= perr_acc_d;
            armed_q      <= armed_d;
            data_out_q   <= data_out_d;
            data_ready_q <= data_ready_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_ready  = data_ready_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and an 8E1 instance at 64 clk per bit.
module tb_uart_rx_param;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_p = 1'b1;
    logic       rd_ack = 1'b0;
    logic       rd_ack_p = 1'b0;
    logic [7:0] data_out, data_out_p;
    logic       data_ready, frame_err, parity_err, overrun_err, busy;
    logic       data_ready_p, frame_err_p, parity_err_p, overrun_err_p, busy_p;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.BAUD_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .RsRx(rx), .rd_ack(rd_ack),
        .data_out(data_out), .data_ready(data_ready), .frame_err(frame_err),
        .parity_err(parity_err), .overrun_err(overrun_err), .busy(busy)
    );

    uart_rx_param #(.BAUD_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_par (
        .clk(clk), .rst_n(rst_n), .RsRx(rx_p), .rd_ack(rd_ack_p),
        .data_out(data_out_p), .data_ready(data_ready_p), .frame_err(frame_err_p),
        .parity_err(parity_err_p), .overrun_err(overrun_err_p), .busy(busy_p)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx_p = v;
        else     rx   = v;
    endtask

    // Line is left at the stop-bit level when the task returns.
    task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                              input logic par_bit, input logic stop_bit);
        set_line(sel, 1'b0);
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, d[i]);
            wait_clk(BIT_CLK);
        end
        if (use_par) begin
            set_line(sel, par_bit);
            wait_clk(BIT_CLK);
        end
        set_line(sel, stop_bit);
        wait_clk(BIT_CLK);
    endtask

    task automatic ack(input bit sel);
        if (sel) rd_ack_p = 1'b1; else rd_ack = 1'b1;
        wait_clk(1);
        if (sel) rd_ack_p = 1'b0; else rd_ack = 1'b0;
        wait_clk(1);
    endtask

    task automatic test_reset;
        wait_clk(3);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data_out got %h exp 00", data_out); end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_data_ready got %b exp 0", data_ready); end
        checks++; if ({frame_err, parity_err, overrun_err} !== 3'b000) begin errors++; $display("FAIL rst_errs got %b exp 000", {frame_err, parity_err, overrun_err}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        rst_n = 1'b1;
        wait_clk(2 * BIT_CLK);
    endtask

    task automatic test_basic;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL a5_ready got %b exp 1", data_ready); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL a5_data got %h exp a5", data_out); end
        checks++; if ({frame_err, parity_err, overrun_err} !== 3'b000) begin errors++; $display("FAIL a5_errs got %b exp 000", {frame_err, parity_err, overrun_err}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy got %b exp 0", busy); end
        ack(1'b0);
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL a5_ack_ready got %b exp 0", data_ready); end
        wait_clk(BIT_CLK);
    endtask

    task automatic test_glitch;
        rx = 1'b0;
        wait_clk(15);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi got %b exp 1", busy); end
        wait_clk(5);
        rx = 1'b1;
        wait_clk(BIT_CLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo got %b exp 0", busy); end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL glitch_ready got %b exp 0", data_ready); end
        wait_clk(BIT_CLK);
    endtask

    task automatic test_parity;
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        checks++; if (parity_err_p !== 1'b1) begin errors++; $display("FAIL par_bad_flag got %b exp 1", parity_err_p); end
        checks++; if (data_out_p !== 8'h03) begin errors++; $display("FAIL par_bad_data got %h exp 03", data_out_p); end
        checks++; if (data_ready_p !== 1'b1) begin errors++; $display("FAIL par_bad_ready got %b exp 1", data_ready_p); end
        ack(1'b1);
        wait_clk(BIT_CLK);
        send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
        checks++; if (parity_err_p !== 1'b0) begin errors++; $display("FAIL par_ok_flag got %b exp 0", parity_err_p); end
        checks++; if ({data_ready_p, frame_err_p, overrun_err_p} !== 3'b100) begin errors++; $display("FAIL par_ok_status got %b exp 100", {data_ready_p, frame_err_p, overrun_err_p}); end
        ack(1'b1);
        wait_clk(BIT_CLK);
    endtask

    task automatic test_frame_break;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b exp 1", frame_err); end
        checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL ferr_data got %h exp 55", data_out); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL ferr_ready got %b exp 1", data_ready); end
        ack(1'b0);
        wait_clk(10 * BIT_CLK);
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL break_no_frame got %b exp 0", data_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy got %b exp 0", busy); end
        rx = 1'b1;
        wait_clk(2 * BIT_CLK);
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL break_release got %b exp 0", data_ready); end
    endtask

    task automatic test_overrun;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        wait_clk(BIT_CLK);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        checks++; if (data_out !== 8'h22) begin errors++; $display("FAIL ovr_data got %h exp 22", data_out); end
        checks++; if ({data_ready, overrun_err} !== 2'b11) begin errors++; $display("FAIL ovr_flags got %b exp 11", {data_ready, overrun_err}); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ovr_ferr got %b exp 0", frame_err); end
        ack(1'b0);
        checks++; if ({data_ready, overrun_err} !== 2'b00) begin errors++; $display("FAIL ovr_ack got %b exp 00", {data_ready, overrun_err}); end
        wait_clk(BIT_CLK);
    endtask

    task automatic test_mid_reset;
        rx = 1'b0;
        wait_clk(BIT_CLK);
        rx = 1'b1;
        wait_clk(4 * BIT_CLK + BIT_CLK / 2);
        rst_n = 1'b0;
        wait_clk(1);
        checks++; if ({busy, data_ready} !== 2'b00) begin errors++; $display("FAIL mrst_status got %b exp 00", {busy, data_ready}); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mrst_data got %h exp 00", data_out); end
        wait_clk(10);
        rst_n = 1'b1;
        wait_clk(6 * BIT_CLK);
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL mrst_no_frame got %b exp 0", data_ready); end
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL mrst_3c_data got %h exp 3c", data_out); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL mrst_3c_ready got %b exp 1", data_ready); end
        checks++; if ({frame_err, parity_err, overrun_err} !== 3'b000) begin errors++; $display("FAIL mrst_3c_errs got %b exp 000", {frame_err, parity_err, overrun_err}); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_glitch;
        test_parity;
        test_frame_break;
        test_overrun;
        test_mid_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
